// File: rtl/gcore_pkg.sv
// Shared core types and constants for the fetch path.
package gcore_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned INSTR_W = 16;

  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t RST_PC = 8'h00;

  // Source of a PC redirect in the current cycle.
  typedef enum logic [1:0] {
    REDIR_NONE,
    REDIR_BRANCH,
    REDIR_REPLAY
  } redir_e;

endpackage

// File: rtl/fetchq_fifo.sv
// Synchronous FIFO for tagged fetch words: push, pop, flush, occupancy count.
// Push and pop together are legal at any fill level, including full.
module fetchq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: tags ROM words with their address, queues them for decode and
// steers the PC for branches and dropped-fetch replays. Optional FETCHQ_BYPASS_EN.
module fetch_queue
  import gcore_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IW    = INSTR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              pc_jump,
  output logic [ADDR_W-1:0] pc_jumpaddr,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [IW-1:0]     imem_data,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  output logic [IW-1:0]     instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
);

  localparam int unsigned          CW       = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0]        FULL_CNT = CW'(DEPTH);

  logic                 if_valid;
  addr_t                if_pc;
  logic [CW-1:0]        count;
  logic [IW+ADDR_W-1:0] head;
  logic                 q_empty;
  logic                 pop;
  logic                 full;
  logic                 push;
  logic                 fifo_pop;
  logic                 bypass;
  redir_e               redir;

  assign imem_addr = pc_addr;
  assign q_empty   = (count == '0);
  assign pop       = instr_valid && instr_ready;
  assign full      = (count == FULL_CNT) && !pop;
  assign fifo_pop  = pop && !q_empty;

`ifdef FETCHQ_BYPASS_EN
  // An arriving word into an empty queue is shown straight away; it is only
  // written to storage if decode does not take it this cycle.
  assign bypass = if_valid && q_empty && !br_valid;
`else
  assign bypass = 1'b0;
`endif

  assign instr_valid = !q_empty || bypass;
  assign instr       = bypass ? imem_data : head[IW+ADDR_W-1:ADDR_W];
  assign instr_pc    = bypass ? if_pc     : head[ADDR_W-1:0];
  assign push        = if_valid && !full && !br_valid && !(bypass && pop);

  always_comb begin
    redir = REDIR_NONE;
    if (!rst) begin
      if (br_valid) begin
        redir = REDIR_BRANCH;
      end else if (if_valid && full) begin
        redir = REDIR_REPLAY;
      end
    end
    pc_jump     = (redir != REDIR_NONE);
    pc_jumpaddr = (redir == REDIR_REPLAY) ? if_pc : br_target;
  end

  // The address shown during a redirect cycle is never fetched for real.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid <= 1'b0;
      if_pc    <= RST_PC;
    end else begin
      if_valid <= !pc_jump;
      if_pc    <= pc_addr;
    end
  end

  fetchq_fifo #(
    .DEPTH (DEPTH),
    .W     (IW + ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (fifo_pop),
    .flush (br_valid),
    .wdata ({imem_data, if_pc}),
    .rdata (head),
    .count (count)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a PC model and a synchronous ROM model.
module tb_fetch_queue;

`ifdef FETCHQ_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pc_addr;
  logic        pc_jump;
  logic [7:0]  pc_jumpaddr;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic        br_valid;
  logic [7:0]  br_target;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  int checks = 0;
  int errors = 0;
  logic [7:0] got [$];

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(4), .IW(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_addr     (pc_addr),
    .pc_jump     (pc_jump),
    .pc_jumpaddr (pc_jumpaddr),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .br_valid    (br_valid),
    .br_target   (br_target),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
  );

  function automatic logic [15:0] rom(input logic [7:0] a);
    return {a ^ 8'hA5, a};
  endfunction

  // PC that cannot stall, and a one-cycle ROM.
  always @(posedge clk) begin
    if (rst)          pc_addr <= 8'h00;
    else if (pc_jump) pc_addr <= pc_jumpaddr;
    else              pc_addr <= pc_addr + 8'h01;
    imem_data <= rom(imem_addr);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Leaves the bench at the start of the release cycle R (PC shows 0).
  task automatic do_reset;
    rst = 1'b1; br_valid = 1'b0; br_target = 8'h00; instr_ready = 1'b0;
    tick;
    br_valid = 1'b1; br_target = 8'h33;
    #1;
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_jump", pc_jump, 0);
    br_valid = 1'b0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  // Gather n delivered words (bounded), checking each word against its tag.
  task automatic collect(input int n);
    int cyc = 0;
    got.delete();
    while (got.size() < n && cyc < 60) begin
      #1;
      if (instr_valid && instr_ready) begin
        got.push_back(instr_pc);
        if (instr !== rom(instr_pc)) chk("word_tag", instr, rom(instr_pc));
      end
      tick;
      cyc++;
    end
    chk("collect_cnt", got.size(), n);
  endtask

  typedef struct {
    logic       br;
    logic [7:0] tgt;
    logic       rdy;
    logic       ev;
    logic [7:0] epc;
    logic       ej;
    logic [7:0] eja;
  } vec_t;

  vec_t vecs [11];

  task automatic branch_test(input logic [7:0] tgt);
    int cyc;
    do_reset;
    repeat (4) tick;
    br_valid = 1'b1; br_target = tgt;
    #1;
    chk("br_jump", pc_jump, 1);
    chk("br_jaddr", pc_jumpaddr, tgt);
    chk("br_queued_head", instr_pc, 8'h00);
    tick;
    br_valid = 1'b0;
    #1;
    chk("br_flush_valid", instr_valid, 0);
    instr_ready = 1'b1;
    cyc = 1;
    while (!instr_valid && cyc < 10) begin
      tick;
      cyc++;
    end
    chk("br_latency", cyc, LAT + 1);
    chk("br_first_pc", instr_pc, tgt);
    tick;
    collect(3);
    for (int i = 0; i < 3; i++) chk("br_seq", got[i], 8'(tgt + 8'(i + 1)));
  endtask

  initial begin
    int first_jump;
    int jumps;
    int popped;
    int cyc;
    logic found;
    logic bad;

`ifdef FETCHQ_BYPASS_EN
    vecs[0]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0, 8'h00};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 1'b0, 8'h00};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 1'b0, 8'h00};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h04, 1'b0, 8'h00};
    vecs[6]  = '{1'b1, 8'h40, 1'b1, 1'b0, 8'h00, 1'b1, 8'h40};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h40, 1'b0, 8'h00};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h41, 1'b0, 8'h00};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h42, 1'b0, 8'h00};
`else
    vecs[0]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00};
    vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 1'b0, 8'h00};
    vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 1'b0, 8'h00};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 1'b0, 8'h00};
    vecs[6]  = '{1'b1, 8'h40, 1'b1, 1'b1, 8'h04, 1'b1, 8'h40};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h40, 1'b0, 8'h00};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h41, 1'b0, 8'h00};
`endif

    // Streaming from reset, then a branch with decode always ready.
    do_reset;
    for (int i = 0; i < 11; i++) begin
      br_valid = vecs[i].br; br_target = vecs[i].tgt; instr_ready = vecs[i].rdy;
      #1;
      chk($sformatf("vec%0d_valid", i), instr_valid, vecs[i].ev);
      if (vecs[i].ev) begin
        chk($sformatf("vec%0d_pc", i), instr_pc, vecs[i].epc);
        chk($sformatf("vec%0d_instr", i), instr, rom(vecs[i].epc));
      end
      chk($sformatf("vec%0d_jump", i), pc_jump, vecs[i].ej);
      if (vecs[i].ej) chk($sformatf("vec%0d_jaddr", i), pc_jumpaddr, vecs[i].eja);
      tick;
    end
    br_valid = 1'b0;

    // Decode stalled: queue fills with 0..3, address 4 keeps being replayed.
    do_reset;
    first_jump = -1; jumps = 0; bad = 1'b0;
    for (int k = 0; k < 15; k++) begin
      #1;
      if (pc_jump) begin
        jumps++;
        if (first_jump < 0) first_jump = k;
        if (pc_jumpaddr !== 8'h04) bad = 1'b1;
      end
      tick;
    end
    chk("stall_first_jump", first_jump, 5);
    chk("stall_jaddr_ok", bad, 0);
    chk("stall_jumps_seen", jumps > 2, 1);
    chk("stall_head_pc", instr_pc, 8'h00);
    instr_ready = 1'b1;
    bad = 1'b0;
    got.delete();
    cyc = 0;
    while (got.size() < 10 && cyc < 60) begin
      #1;
      if (pc_jump) bad = 1'b1;
      if (instr_valid) got.push_back(instr_pc);
      tick;
      cyc++;
    end
    chk("resume_cnt", got.size(), 10);
    for (int i = 0; i < got.size(); i++) chk("resume_seq", got[i], 8'(i));
    chk("resume_no_jump", bad, 0);

    // Branches with three entries queued, including address wrap.
    branch_test(8'h40);
    branch_test(8'hFE);

    // Branch in the same cycle as the replay drop of 0x07.
    do_reset;
    popped = 0; found = 1'b0; bad = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      instr_ready = (popped < 3);
      #1;
      if (pc_jump) begin
        if (pc_jumpaddr === 8'h07) begin
          found = 1'b1;
          br_valid = 1'b1; br_target = 8'h20;
          #1;
          chk("brrep_jump", pc_jump, 1);
          chk("brrep_jaddr", pc_jumpaddr, 8'h20);
        end else begin
          bad = 1'b1;
        end
      end
      if (instr_valid && instr_ready) popped++;
      tick;
    end
    br_valid = 1'b0;
    chk("brrep_found", found, 1);
    chk("brrep_early_jump", bad, 0);
    instr_ready = 1'b1;
    collect(6);
    bad = 1'b0;
    for (int i = 0; i < got.size(); i++) if (got[i] === 8'h07) bad = 1'b1;
    chk("brrep_no_07", bad, 0);
    for (int i = 0; i < got.size(); i++) chk("brrep_seq", got[i], 8'(8'h20 + 8'(i)));

    // Reset pulse with a full queue while a replay would be issued.
    do_reset;
    repeat (9) tick;
    rst = 1'b1;
    #1;
    chk("rstpulse_jump", pc_jump, 0);
    tick;
    rst = 1'b0;
    instr_ready = 1'b1;
    #1;
    chk("rstpulse_valid", instr_valid, 0);
    chk("rstpulse_nojump", pc_jump, 0);
    cyc = 0;
    while (!instr_valid && cyc < 10) begin
      tick;
      cyc++;
    end
    chk("rstpulse_latency", cyc, LAT);
    chk("rstpulse_pc", instr_pc, 8'h00);
    tick;
    collect(3);
    for (int i = 0; i < 3; i++) chk("rstpulse_seq", got[i], 8'(i + 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
